// File: rtl/led_mode_pkg.sv
// Purpose: mode encoding and start patterns shared by the LED pattern engine.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package led_mode_pkg;

    typedef enum logic [1:0] {
        MODE_CHASE  = 2'd0,
        MODE_FILL   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    // Returned 32 bits wide; callers size-cast down to their LED count.
    function automatic logic [31:0] start_pattern(input mode_t m);
        return (m == MODE_BLINK) ? 32'hFFFF_FFFF : 32'h0000_0001;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Purpose: prescaler emitting one step tick every DIV enabled clocks.
// Latency: tick is combinational from the count register (asserts during the DIV-th enabled clock).
// Backpressure: en=0 freezes the count; clr/reset force the count to 0 and suppress the tick.
module led_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic          last;

    assign last = (cnt == CW'(DIV - 1));
    assign tick = en & last & ~clr & ~reset;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_mode_engine.sv
// Purpose: LED pattern generator (chase, fill, bounce, blink) with cycle-complete pulse.
// Latency: OUT and cycle_done update on the edge that takes a step; a mode change restarts next edge.
// Backpressure: en=0 holds pattern and prescaler; mode change and reset act regardless of en.
module led_mode_engine
    import led_mode_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] OUT,
    output logic             cycle_done
);

    localparam int KW = $clog2(WIDTH + 1);

    mode_t            mode_i;
    mode_t            mode_q;
    logic             chg;
    logic             load;
    logic             tick;
    logic             wrap;

    logic [WIDTH-1:0] chase_q;
    logic [KW-1:0]    fill_k;
    logic [KW-1:0]    fill_p;
    logic [WIDTH-1:0] fill_pat;
    logic [WIDTH-1:0] bnc_q;
    logic [WIDTH-1:0] bnc_nxt;
    logic             bnc_dir;
    logic             blink_q;
    logic             done_q;

    assign mode_i = mode_t'(mode);
    assign chg    = (mode_i != mode_q);
    assign load   = reset | chg;

    led_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (chg),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (load) begin
            mode_q <= mode_i;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            chase_q <= WIDTH'(start_pattern(MODE_CHASE));
        end else if (tick && mode_q == MODE_CHASE) begin
            chase_q <= {chase_q[WIDTH-2:0], chase_q[WIDTH-1]};
        end
    end

    // Dot falls from bit0 toward the stack; landing grows the stack by one.
    always_ff @(posedge clk) begin
        if (load) begin
            fill_k <= '0;
            fill_p <= '0;
        end else if (tick && mode_q == MODE_FILL) begin
            if (fill_k == KW'(WIDTH)) begin
                fill_k <= '0;
                fill_p <= '0;
            end else if (fill_p == KW'(WIDTH - 1) - fill_k) begin
                fill_k <= fill_k + KW'(1);
                fill_p <= '0;
            end else begin
                fill_p <= fill_p + KW'(1);
            end
        end
    end

    always_comb begin
        fill_pat = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i >= WIDTH - int'(fill_k)) fill_pat[i] = 1'b1;
            if (fill_k != KW'(WIDTH) && fill_p == KW'(i)) fill_pat[i] = 1'b1;
        end
    end

    // Direction flips on arrival at either end so the ends are not repeated.
    assign bnc_nxt = bnc_dir ? (bnc_q >> 1) : (bnc_q << 1);

    always_ff @(posedge clk) begin
        if (load) begin
            bnc_q   <= WIDTH'(start_pattern(MODE_BOUNCE));
            bnc_dir <= 1'b0;
        end else if (tick && mode_q == MODE_BOUNCE) begin
            bnc_q <= bnc_nxt;
            if (bnc_nxt[WIDTH-1]) begin
                bnc_dir <= 1'b1;
            end else if (bnc_nxt[0]) begin
                bnc_dir <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            blink_q <= 1'b0;
        end else if (tick && mode_q == MODE_BLINK) begin
            blink_q <= ~blink_q;
        end
    end

    always_comb begin
        wrap = 1'b0;
        case (mode_q)
            MODE_CHASE:  wrap = chase_q[WIDTH-1];
            MODE_FILL:   wrap = (fill_k == KW'(WIDTH));
            MODE_BOUNCE: wrap = bnc_dir & bnc_q[1];
            MODE_BLINK:  wrap = blink_q;
            default:     wrap = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (load) begin
            done_q <= 1'b0;
        end else begin
            done_q <= tick & wrap;
        end
    end

    assign cycle_done = done_q;

    always_comb begin
        OUT = '0;
        case (mode_q)
            MODE_CHASE:  OUT = chase_q;
            MODE_FILL:   OUT = fill_pat;
            MODE_BOUNCE: OUT = bnc_q;
            MODE_BLINK:  OUT = blink_q ? '0 : WIDTH'(start_pattern(MODE_BLINK));
            default:     OUT = '0;
        endcase
    end

endmodule

// File: tb/tb_led_mode_engine.sv
// Directed bench for led_mode_engine: WIDTH=8 with DIV=1 and DIV=3 instances on shared inputs.
module tb_led_mode_engine;

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic [7:0] out1;
    logic       done1;
    logic [7:0] out3;
    logic       done3;

    int compared = 0;
    int mismatched = 0;

    led_mode_engine #(.WIDTH(8), .DIV(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .OUT        (out1),
        .cycle_done (done1)
    );

    led_mode_engine #(.WIDTH(8), .DIV(3)) dut3 (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .OUT        (out3),
        .cycle_done (done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] chase_tab [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] fill_tab  [37] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                   8'h81, 8'h82, 8'h84, 8'h88, 8'h90, 8'hA0, 8'hC0,
                                   8'hC1, 8'hC2, 8'hC4, 8'hC8, 8'hD0, 8'hE0,
                                   8'hE1, 8'hE2, 8'hE4, 8'hE8, 8'hF0,
                                   8'hF1, 8'hF2, 8'hF4, 8'hF8,
                                   8'hF9, 8'hFA, 8'hFC,
                                   8'hFD, 8'hFE,
                                   8'hFF, 8'hFF, 8'h01};
    logic [7:0] bnc_tab   [14] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                   8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    logic [7:0] div3_tab  [6]  = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h04};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        mode  = 2'd0;
        cyc();
        chk("reset_out", out1, 8'h01);
        chk("reset_done", {7'd0, done1}, 8'h00);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            cyc();
            chk($sformatf("chase_out[%0d]", i), out1, chase_tab[i]);
            chk($sformatf("chase_done[%0d]", i), {7'd0, done1}, {7'd0, i == 7});
        end

        mode = 2'd1;
        cyc();
        chk("fill_start", out1, 8'h01);
        chk("fill_start_done", {7'd0, done1}, 8'h00);
        for (int i = 0; i < 37; i++) begin
            cyc();
            chk($sformatf("fill_out[%0d]", i), out1, fill_tab[i]);
            chk($sformatf("fill_done[%0d]", i), {7'd0, done1}, {7'd0, i == 36});
        end

        for (int i = 0; i < 10; i++) cyc();
        chk("fill_at_84", out1, 8'h84);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("hold_out[%0d]", i), out1, 8'h84);
            chk($sformatf("hold_done[%0d]", i), {7'd0, done1}, 8'h00);
        end
        en = 1'b1;
        cyc();
        chk("resume_88", out1, 8'h88);
        for (int i = 0; i < 6; i++) cyc();
        chk("fill_at_c4", out1, 8'hC4);

        mode = 2'd0;
        cyc();
        chk("chg_to_chase", out1, 8'h01);
        chk("chg_no_done", {7'd0, done1}, 8'h00);
        cyc();
        chk("chase_after_chg", out1, 8'h02);

        mode = 2'd2;
        cyc();
        chk("bounce_start", out1, 8'h01);
        for (int i = 0; i < 14; i++) begin
            cyc();
            chk($sformatf("bounce_out[%0d]", i), out1, bnc_tab[i]);
            chk($sformatf("bounce_done[%0d]", i), {7'd0, done1}, {7'd0, i == 13});
        end
        cyc();
        chk("bounce_no_dwell", out1, 8'h02);
        for (int i = 0; i < 7; i++) cyc();
        chk("bounce_mid_right", out1, 8'h40);
        reset = 1'b1;
        cyc();
        chk("bounce_reset_out", out1, 8'h01);
        chk("bounce_reset_done", {7'd0, done1}, 8'h00);
        reset = 1'b0;
        cyc();
        chk("bounce_after_reset", out1, 8'h02);

        mode = 2'd3;
        cyc();
        chk("blink_start", out1, 8'hFF);
        chk("blink_start_done", {7'd0, done1}, 8'h00);
        cyc();
        chk("blink_off", out1, 8'h00);
        chk("blink_off_done", {7'd0, done1}, 8'h00);
        cyc();
        chk("blink_on", out1, 8'hFF);
        chk("blink_on_done", {7'd0, done1}, 8'h01);

        mode  = 2'd0;
        reset = 1'b1;
        cyc();
        chk("div3_reset", out3, 8'h01);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk($sformatf("div3_out[%0d]", i), out3, div3_tab[i]);
        end
        en = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk("div3_hold", out3, 8'h04);
        en = 1'b1;
        cyc();
        chk("div3_resume1", out3, 8'h04);
        cyc();
        chk("div3_resume2", out3, 8'h04);
        cyc();
        chk("div3_resume3", out3, 8'h08);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/led_mode_engine.md
LED_MODE_ENGINE -- requirements
Module: led_mode_engine

Interface
REQ-001 Parameter WIDTH, default 8: LED count; legal range 4..32.
REQ-002 Parameter DIV, default 1: enabled clocks per pattern step; legal range 1..65535.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 en  input  1: step enable; when 0, the pattern and prescaler freeze.
REQ-006 mode  input  2: 0 CHASE, 1 FILL, 2 BOUNCE, 3 BLINK.
REQ-007 OUT  output  WIDTH: LED pattern, registered.
REQ-008 cycle_done  output  1: one-clock pulse on the step that completes a full pattern cycle, registered.

Function
REQ-009 The prescaler SHALL count enabled clocks 0..DIV-1; a step occurs on an enabled clock with count==DIV-1; the count then returns to 0; DIV=1 steps on every enabled clock.
REQ-010 en=0 SHALL hold OUT, the internal state and the prescaler count; cycle_done SHALL be 0.
REQ-011 The mode input SHALL be compared every clock with registered mode_q; on mismatch the next edge loads mode_q<=mode, the start pattern of the new mode and prescaler=0, regardless of en; cycle_done=0.
REQ-012 Start patterns: CHASE, FILL and BOUNCE SHALL start at OUT=1 (bit0); BLINK SHALL start at all-ones.
REQ-013 CHASE: each step shifts the one-hot left; from bit WIDTH-1 it wraps to bit0 and pulses cycle_done; period WIDTH steps.
REQ-014 FILL: state is stack height k (0..WIDTH) and dot position p; OUT = top k bits set OR bit p (dot omitted when k==WIDTH).
REQ-015 FILL step: if k<WIDTH and p<WIDTH-1-k, then p<=p+1; if k<WIDTH and p==WIDTH-1-k, the dot lands: k<=k+1, p<=0; if k==WIDTH, then k<=0, p<=0, OUT=1 and cycle_done pulses.
REQ-016 FILL period SHALL be WIDTH*(WIDTH+1)/2+1 steps; this is 37 for WIDTH=8.
REQ-017 BOUNCE: the one-hot moves left to bit WIDTH-1, then right to bit0; the direction reverses at each end without dwelling; cycle_done pulses on arrival at bit0; period 2*(WIDTH-1) steps.
REQ-018 BLINK: OUT alternates all-ones and all-zeros each step; cycle_done pulses on the return to all-ones.
REQ-019 cycle_done SHALL assert only on the same edge OUT takes its wrapped value; it is never asserted on reset or on a mode restart.
REQ-020 Step arithmetic SHALL be in unsigned widths sized by $clog2(WIDTH+1) and $clog2(DIV); no truncation at WIDTH=32 or DIV=65535.

Reset
REQ-021 reset=1 SHALL, on the next edge, set mode_q<=mode, prescaler=0, FILL k=0/p=0, BOUNCE direction=left, OUT=start pattern of mode, cycle_done=0.
REQ-022 reset SHALL take priority over en, mode change and step, including mid-pattern.

Structure
REQ-023 Package led_mode_pkg SHALL hold the mode encoding constants (MODE_CHASE..MODE_BLINK) and the start-pattern function.
REQ-024 The prescaler SHALL be sub-module led_tick_gen (parameter DIV; ports clk, reset, en, clr, tick).
REQ-025 All pattern logic SHALL live in one registered process per mode state plus one output mux; there SHALL be no combinational path from input to OUT.

Verification (WIDTH=8, DIV=1 unless stated)
REQ-026 Stimulus: reset, mode=0, en=1 -> OUT 01,02,04,...,80,01, with cycle_done high only alongside the second 01.
REQ-027 Stimulus: mode=1, en=1 -> OUT 01,02,...,80,81,82,...,C0,C1,...,FF, then 01 on step 37 with cycle_done.
REQ-028 Stimulus: mode=2 -> OUT 01..80..01, period 14 steps, with no repeat of 80; mode=3 -> FF,00,FF with cycle_done on the second FF.
REQ-029 Stimulus: en=0 for 5 clocks mid-FILL at OUT=84 -> OUT holds 84; en=1 -> continues 88; DIV=3 -> OUT changes every 3rd enabled clock.
REQ-030 Stimulus: mode 1->0 at OUT=C4 -> next edge OUT=01, no cycle_done; reset with en=1 mid-BOUNCE -> OUT=01, and the next step gives 02.
